// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write, busy-set and clear signals of the multi-port register file
interface regfile_mp_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);
    logic                clear_req;
    logic                ready;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr0_en;
    logic [AW-1:0]       wr0_addr;
    logic [XLEN-1:0]     wr0_data;
    logic                wr1_en;
    logic [AW-1:0]       wr1_addr;
    logic [XLEN-1:0]     wr1_data;
    logic                set_busy_en;
    logic [AW-1:0]       set_busy_addr;
    modport master (
        output clear_req, rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, set_busy_en, set_busy_addr,
        input  ready, rd_data, rd_busy
    );
    modport slave (
        input  clear_req, rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, set_busy_en, set_busy_addr,
        output ready, rd_data, rd_busy
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with dual write, bypass, busy scoreboard and clear sweep
module regfile_mp #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         reset_n,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t           state;
    logic [AW-1:0]    clr_idx;
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic             run;
    logic             w0;
    logic             w1;
    logic             sb;
    // Writes and busy sets only take effect in RUN on an edge that is not starting a sweep
    assign run = reset_n && state == RUN && !bus.clear_req;
    assign w0 = run && bus.wr0_en && !(ZERO_REG != 0 && bus.wr0_addr == '0);
    assign w1 = run && bus.wr1_en && !(ZERO_REG != 0 && bus.wr1_addr == '0);
    assign sb = run && bus.set_busy_en && !(ZERO_REG != 0 && bus.set_busy_addr == '0);
    assign set_mask = sb ? NREGS'(1) << bus.set_busy_addr : '0;
    assign clr_mask = (w0 ? NREGS'(1) << bus.wr0_addr : '0) | (w1 ? NREGS'(1) << bus.wr1_addr : '0);
    // Sweep/run sequencer; ready is registered so it rises with the RUN state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= CLEAR;
            clr_idx   <= '0;
            bus.ready <= 1'b0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == AW'(NREGS - 1)) begin
                state     <= RUN;
                bus.ready <= 1'b1;
            end
        end else if (bus.clear_req) begin
            state     <= CLEAR;
            clr_idx   <= '0;
            bus.ready <= 1'b0;
        end
    end
    // Storage has no reset: the sweep zeroes one entry per cycle; wr1 is last so it wins a collision
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            regs[clr_idx] <= '0;
        end else begin
            if (w0) regs[bus.wr0_addr] <= bus.wr0_data;
            if (w1) regs[bus.wr1_addr] <= bus.wr1_data;
        end
    end
    // Scoreboard: writes retire producers, a same-edge set re-arms the bit
    always_ff @(posedge clk) begin
        busy <= run ? (busy & ~clr_mask) | set_mask : '0;
    end
    genvar k;
    for (k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          h0;
        logic          h1;
        logic          hs;
        assign a  = bus.rd_addr[k*AW +: AW];
        assign h0 = w0 && bus.wr0_addr == a;
        assign h1 = w1 && bus.wr1_addr == a;
        assign hs = sb && bus.set_busy_addr == a;
        assign bus.rd_data[k*XLEN +: XLEN] =
            (state != RUN || (ZERO_REG != 0 && a == '0)) ? '0 :
            (BYPASS != 0 && h1) ? bus.wr1_data :
            (BYPASS != 0 && h0) ? bus.wr0_data : regs[a];
        assign bus.rd_busy[k] = state == RUN && busy[a] && !(BYPASS != 0 && (h0 || h1) && !hs);
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors against a bypass/zero-reg instance and a plain instance
module tb_regfile_mp;
    localparam int XLEN = 64, NREGS = 32, NRD = 2, AW = 5;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear_req = 1'b0;
    logic w0e = 1'b0, w1e = 1'b0, sbe = 1'b0;
    logic [AW-1:0] w0a = '0, w1a = '0, sba = '0;
    logic [XLEN-1:0] w0d = '0, w1d = '0;
    logic [NRD*AW-1:0] rd_addr = '0;
    int errors = 0;
    int checks = 0;
    typedef struct packed {
        logic w0e; logic [4:0] w0a; logic [63:0] w0d;
        logic w1e; logic [4:0] w1a; logic [63:0] w1d;
        logic sbe; logic [4:0] sba;
        logic [4:0] r0; logic [4:0] r1;
        logic [63:0] a0; logic [63:0] a1; logic [1:0] ab;
        logic [63:0] b0; logic [63:0] b1; logic [1:0] bb;
    } vec_t;
    vec_t tv [16];
    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) ia ();
    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) ib ();
    assign ia.clear_req = clear_req;     assign ib.clear_req = clear_req;
    assign ia.rd_addr = rd_addr;         assign ib.rd_addr = rd_addr;
    assign ia.wr0_en = w0e;              assign ib.wr0_en = w0e;
    assign ia.wr0_addr = w0a;            assign ib.wr0_addr = w0a;
    assign ia.wr0_data = w0d;            assign ib.wr0_data = w0d;
    assign ia.wr1_en = w1e;              assign ib.wr1_en = w1e;
    assign ia.wr1_addr = w1a;            assign ib.wr1_addr = w1a;
    assign ia.wr1_data = w1d;            assign ib.wr1_data = w1d;
    assign ia.set_busy_en = sbe;         assign ib.set_busy_en = sbe;
    assign ia.set_busy_addr = sba;       assign ib.set_busy_addr = sba;
    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ia.slave));
    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ib.slave));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        w0e = 1'b0; w1e = 1'b0; sbe = 1'b0; clear_req = 1'b0;
    endtask
    task automatic chk_ready(input string tag, input logic exp);
        chk({tag, "_ready_a"}, 64'(ia.ready), 64'(exp));
        chk({tag, "_ready_b"}, 64'(ib.ready), 64'(exp));
    endtask
    task automatic chk_zero_all(input string tag);
        for (int r = 0; r < NREGS; r++) begin
            rd_addr = {AW'(r), AW'(NREGS - 1 - r)};
            #1;
            chk({tag, "_a_d0"}, ia.rd_data[63:0], '0);
            chk({tag, "_a_d1"}, ia.rd_data[127:64], '0);
            chk({tag, "_a_busy"}, 64'(ia.rd_busy), '0);
            chk({tag, "_b_d0"}, ib.rd_data[63:0], '0);
            chk({tag, "_b_d1"}, ib.rd_data[127:64], '0);
            chk({tag, "_b_busy"}, 64'(ib.rd_busy), '0);
        end
    endtask
    initial begin
        tv[0]  = '{1, 5, 'hAAAA, 1, 5, 'h5555, 0, 0, 5, 0, 'h5555, 0, 0, 0, 0, 0};
        tv[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 'h5555, 'h5555, 0, 'h5555, 'h5555, 0};
        tv[2]  = '{1, 0, 'hDEAD, 0, 0, 0, 1, 0, 0, 5, 0, 'h5555, 0, 0, 'h5555, 0};
        tv[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hDEAD, 'hDEAD, 3};
        tv[4]  = '{0, 0, 0, 0, 0, 0, 1, 7, 7, 3, 0, 0, 0, 0, 0, 0};
        tv[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1, 0, 'hDEAD, 3};
        tv[6]  = '{0, 0, 0, 1, 7, 'h77, 0, 0, 7, 7, 'h77, 'h77, 0, 0, 0, 3};
        tv[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 'h77, 'h77, 0, 'h77, 'h77, 0};
        tv[8]  = '{1, 7, 'h88, 0, 0, 0, 1, 7, 7, 7, 'h88, 'h88, 0, 'h77, 'h77, 0};
        tv[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 'h88, 0, 1, 'h88, 'hDEAD, 3};
        tv[10] = '{1, 3, 'h1234, 0, 0, 0, 0, 0, 3, 3, 'h1234, 'h1234, 0, 0, 0, 0};
        tv[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 5, 'h1234, 'h5555, 0, 'h1234, 'h5555, 0};
        tv[12] = '{1, 9, 'h99, 1, 10, 'hA0, 0, 0, 9, 10, 'h99, 'hA0, 0, 0, 0, 0};
        tv[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 10, 9, 'hA0, 'h99, 0, 'hA0, 'h99, 0};
        tv[14] = '{0, 0, 0, 1, 0, 'hBEEF, 0, 0, 0, 1, 0, 0, 0, 'hDEAD, 0, 1};
        tv[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hBEEF, 'hBEEF, 0};
        reset_n = 1'b0;
        tick();
        tick();
        chk_ready("rst", 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            rd_addr = {AW'(i), AW'(i)};
            #1;
            chk_ready("sweep0", 1'b0);
            chk("sweep0_a_d", ia.rd_data[63:0], '0);
            chk("sweep0_b_busy", 64'(ib.rd_busy), '0);
            tick();
        end
        chk_ready("sweep0_done", 1'b1);
        chk_zero_all("init");
        for (int i = 0; i < 16; i++) begin
            w0e = tv[i].w0e; w0a = tv[i].w0a; w0d = tv[i].w0d;
            w1e = tv[i].w1e; w1a = tv[i].w1a; w1d = tv[i].w1d;
            sbe = tv[i].sbe; sba = tv[i].sba;
            rd_addr = {tv[i].r1, tv[i].r0};
            #1;
            chk($sformatf("v%0d_a_d0", i), ia.rd_data[63:0], tv[i].a0);
            chk($sformatf("v%0d_a_d1", i), ia.rd_data[127:64], tv[i].a1);
            chk($sformatf("v%0d_a_busy", i), 64'(ia.rd_busy), 64'(tv[i].ab));
            chk($sformatf("v%0d_b_d0", i), ib.rd_data[63:0], tv[i].b0);
            chk($sformatf("v%0d_b_d1", i), ib.rd_data[127:64], tv[i].b1);
            chk($sformatf("v%0d_b_busy", i), 64'(ib.rd_busy), 64'(tv[i].bb));
            tick();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            w0e = 1'b1; w0a = AW'(i); w0d = 64'(i);
            w1e = 1'b1; w1a = AW'(i + 16); w1d = 64'(i + 16);
            tick();
        end
        idle();
        rd_addr = {AW'(4), AW'(17)};
        #1;
        chk("fill_a_17", ia.rd_data[63:0], 64'd17);
        chk("fill_b_4", ib.rd_data[127:64], 64'd4);
        clear_req = 1'b1;
        w0e = 1'b1; w0a = 2; w0d = 'hFF;
        sbe = 1'b1; sba = 6;
        #1;
        chk_ready("creq", 1'b1);
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            rd_addr = {AW'(2), AW'(31 - i)};
            #1;
            chk_ready("sweep1", 1'b0);
            chk("sweep1_a_d1", ia.rd_data[127:64], '0);
            chk("sweep1_b_d0", ib.rd_data[63:0], '0);
            chk("sweep1_b_busy", 64'(ib.rd_busy), '0);
            tick();
        end
        idle();
        chk_ready("sweep1_done", 1'b1);
        chk_zero_all("cleared");
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk_ready("part", 1'b0);
            tick();
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            chk_ready("restart", 1'b0);
            tick();
        end
        chk_ready("restart_done", 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
